// File: rtl/btn_debounce_1khz.sv
// Front-panel debouncer: synchronizes raw button/coin inputs and commits a new level
// only after it has disagreed with the current one for STABLE_MS rising edges of the 1 kHz input.
module btn_debounce_1khz #(
    parameter int N_BTN     = 4,
    parameter int STABLE_MS = 20,
    parameter int CNT_W     = 5
) (
    input  logic             i_clk,
    input  logic             reset,
    input  logic             i_clk_1khz,
    input  logic [N_BTN-1:0] i_btn,
    output logic [N_BTN-1:0] o_btn_level,
    output logic [N_BTN-1:0] o_btn_pulse,
    output logic             o_tick
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_MS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             slow_q_reg;
    logic             slow_d_reg;
    logic [N_BTN-1:0] sync1_reg;
    logic [N_BTN-1:0] sync2_reg;
    logic             tick;

    // History flops reset high so a 1 kHz input already high at reset is not seen as an edge.
    always_ff @(posedge i_clk) begin
        if (reset) begin
            slow_q_reg <= 1'b1;
            slow_d_reg <= 1'b1;
            sync1_reg  <= '0;
            sync2_reg  <= '0;
        end else begin
            slow_q_reg <= i_clk_1khz;
            slow_d_reg <= slow_q_reg;
            sync1_reg  <= i_btn;
            sync2_reg  <= sync1_reg;
        end
    end

    assign tick   = slow_q_reg & ~slow_d_reg;
    assign o_tick = tick;

    generate
        for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
            logic             btn_s;
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic             level_reg;
            logic             level_next;
            logic             pulse_reg;
            logic             pulse_next;

            assign btn_s = sync2_reg[gi];

            // Any cycle where the input agrees with the level restarts the count, so a bounce
            // anywhere inside the window costs the whole window.
            always_comb begin
                cnt_next   = cnt_reg;
                level_next = level_reg;
                pulse_next = 1'b0;
                if (btn_s == level_reg) begin
                    cnt_next = '0;
                end else if (tick) begin
                    if (cnt_reg == CNT_LAST) begin
                        level_next = btn_s;
                        pulse_next = btn_s;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end
            end

            always_ff @(posedge i_clk) begin
                if (reset) begin
                    cnt_reg   <= '0;
                    level_reg <= 1'b0;
                    pulse_reg <= 1'b0;
                end else begin
                    cnt_reg   <= cnt_next;
                    level_reg <= level_next;
                    pulse_reg <= pulse_next;
                end
            end

            assign o_btn_level[gi] = level_reg;
            assign o_btn_pulse[gi] = pulse_reg;
        end
    endgenerate

endmodule

// File: tb/tb_btn_debounce_1khz.sv
// Scoreboard bench for btn_debounce_1khz: a history-based reference model predicts every
// tick, level change and press pulse; a monitor compares each output event the DUT shows.
module tb_btn_debounce_1khz;
    localparam int N_BTN     = 4;
    localparam int STABLE_MS = 3;
    localparam int CNT_W     = 2;
    localparam int MAXC      = 20000;

    logic             i_clk;
    logic             reset;
    logic             i_clk_1khz;
    logic [N_BTN-1:0] i_btn;
    logic [N_BTN-1:0] o_btn_level;
    logic [N_BTN-1:0] o_btn_pulse;
    logic             o_tick;

    btn_debounce_1khz #(
        .N_BTN    (N_BTN),
        .STABLE_MS(STABLE_MS),
        .CNT_W    (CNT_W)
    ) dut (
        .i_clk      (i_clk),
        .reset      (reset),
        .i_clk_1khz (i_clk_1khz),
        .i_btn      (i_btn),
        .o_btn_level(o_btn_level),
        .o_btn_pulse(o_btn_pulse),
        .o_tick     (o_tick)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    typedef struct {
        int               cyc;
        logic             tk;
        logic [N_BTN-1:0] lvl;
        logic [N_BTN-1:0] pls;
    } ev_t;

    ev_t exp_q[$];
    int  n_vec  = 0;
    int  n_fail = 0;
    bit  done   = 1'b0;
    bit  en_1k  = 1'b0;

    // Input history, one entry per clock cycle (cycle m = interval after the m-th rising edge).
    bit               r_h  [MAXC];
    bit               s_h  [MAXC];
    logic [N_BTN-1:0] b_h  [MAXC];
    int               tp_h [MAXC];

    function automatic bit get_r(int c);
        return (c < 0) ? 1'b1 : r_h[c];
    endfunction

    function automatic bit get_s(int c);
        return (c < 0) ? 1'b1 : s_h[c];
    endfunction

    function automatic int get_tp(int c);
        return (c < 0) ? 0 : tp_h[c];
    endfunction

    // A tick is a 0->1 of the 1 kHz input seen one cycle late; reset hides edges for two cycles.
    function automatic bit tick_at(int m);
        return !get_r(m - 1) && !get_r(m - 2) && get_s(m - 1) && !get_s(m - 2);
    endfunction

    function automatic logic [N_BTN-1:0] btn_s_at(int m);
        if (get_r(m - 1) || get_r(m - 2) || m < 2) return '0;
        return b_h[m - 2];
    endfunction

    // Reference model: a level flips once the number of ticks in the current unbroken
    // disagreement run reaches STABLE_MS.
    initial begin
        int               m;
        bit               tk;
        logic [N_BTN-1:0] bs;
        logic [N_BTN-1:0] lvl;
        logic [N_BTN-1:0] lvl_prev;
        logic [N_BTN-1:0] pls;
        logic [N_BTN-1:0] lvl_n;
        logic [N_BTN-1:0] pls_n;
        int               run_start [N_BTN];
        ev_t              e;
        m        = 0;
        lvl      = '0;
        lvl_prev = '0;
        pls      = '0;
        for (int k = 0; k < N_BTN; k++) run_start[k] = 1;
        r_h[0]  = 1'b1;
        s_h[0]  = 1'b1;
        b_h[0]  = '0;
        tp_h[0] = 0;
        forever begin
            @(negedge i_clk);
            m++;
            if (m >= MAXC) begin
                $display("FAIL model_capacity: cycle %0d exceeds history size %0d", m, MAXC);
                $fatal(1);
            end
            r_h[m]  = reset;
            s_h[m]  = i_clk_1khz;
            b_h[m]  = i_btn;
            tk      = tick_at(m);
            tp_h[m] = get_tp(m - 1) + (tk ? 1 : 0);
            bs      = btn_s_at(m);
            if (tk || pls != '0 || lvl != lvl_prev) begin
                e.cyc = m;
                e.tk  = tk;
                e.lvl = lvl;
                e.pls = pls;
                exp_q.push_back(e);
            end
            lvl_prev = lvl;
            lvl_n    = lvl;
            pls_n    = '0;
            if (r_h[m]) begin
                lvl_n = '0;
                for (int k = 0; k < N_BTN; k++) run_start[k] = m + 1;
            end else begin
                for (int k = 0; k < N_BTN; k++) begin
                    if (bs[k] == lvl[k]) begin
                        run_start[k] = m + 1;
                    end else if (tk && (tp_h[m] - get_tp(run_start[k] - 1)) == STABLE_MS) begin
                        lvl_n[k]     = bs[k];
                        pls_n[k]     = bs[k];
                        run_start[k] = m + 1;
                    end
                end
            end
            lvl = lvl_n;
            pls = pls_n;
        end
    end

    // Monitor: every visible output event pops one prediction.
    initial begin
        int               m;
        logic [N_BTN-1:0] prev;
        ev_t              e;
        m    = 0;
        prev = '0;
        forever begin
            @(negedge i_clk);
            #1;
            m++;
            if (m == 1) begin
                n_vec++;
                if (o_tick !== 1'b0 || o_btn_level !== '0 || o_btn_pulse !== '0) begin
                    n_fail++;
                    $display("FAIL reset_state: tick=%b level=%b pulse=%b, required all zero",
                             o_tick, o_btn_level, o_btn_pulse);
                end
            end
            while (exp_q.size() > 0 && exp_q[0].cyc < m) begin
                e = exp_q.pop_front();
                n_vec++;
                n_fail++;
                $display("FAIL missed_event cycle %0d: DUT showed no event, required tick=%b level=%b pulse=%b",
                         e.cyc, e.tk, e.lvl, e.pls);
            end
            if (o_tick !== 1'b0 || o_btn_pulse !== '0 || o_btn_level !== prev) begin
                n_vec++;
                if (exp_q.size() == 0 || exp_q[0].cyc != m) begin
                    n_fail++;
                    $display("FAIL unexpected_event cycle %0d: tick=%b level=%b pulse=%b, required no event",
                             m, o_tick, o_btn_level, o_btn_pulse);
                end else begin
                    e = exp_q.pop_front();
                    if (o_tick !== e.tk || o_btn_level !== e.lvl || o_btn_pulse !== e.pls) begin
                        n_fail++;
                        $display("FAIL event cycle %0d: tick=%b level=%b pulse=%b, required tick=%b level=%b pulse=%b",
                                 m, o_tick, o_btn_level, o_btn_pulse, e.tk, e.lvl, e.pls);
                    end else begin
                        $display("event cycle %0d: tick=%b level=%b pulse=%b ok",
                                 m, o_tick, o_btn_level, o_btn_pulse);
                    end
                end
                prev = o_btn_level;
            end
        end
    end

    // 1 kHz stand-in: toggles every 50 cycles while enabled, otherwise holds its value.
    initial begin
        int cnt;
        cnt        = 0;
        i_clk_1khz = 1'b1;
        forever begin
            @(posedge i_clk);
            #1;
            if (en_1k) begin
                cnt++;
                if (cnt == 50) begin
                    i_clk_1khz = ~i_clk_1khz;
                    cnt        = 0;
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        i_btn = '0;
        wait_cyc(10);
        reset = 1'b0;
        wait_cyc(5);
        en_1k = 1'b1;
        wait_cyc(150 + int'($urandom_range(0, 99)));
        i_btn[0] = 1'b1;
        wait_cyc(500);
        i_btn[1] = 1'b1;
        wait_cyc(200);
        i_btn[1] = 1'b0;
        wait_cyc(10);
        i_btn[1] = 1'b1;
        wait_cyc(500);
        i_btn[0] = 1'b0;
        wait_cyc(500);
        i_btn[3:2] = 2'b11;
        wait_cyc(500);
        i_btn[0] = 1'b1;
        wait_cyc(400);
        reset = 1'b1;
        wait_cyc(1);
        reset = 1'b0;
        wait_cyc(500);
        // Stalled 1 kHz input: inputs churn but nothing may commit.
        en_1k = 1'b0;
        repeat (20) begin
            i_btn = N_BTN'($urandom);
            wait_cyc(int'($urandom_range(1, 40)));
        end
        en_1k = 1'b1;
        repeat (40) begin
            i_btn = i_btn ^ N_BTN'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) begin
                reset = 1'b1;
                wait_cyc(1);
                reset = 1'b0;
            end
            wait_cyc(int'($urandom_range(1, 200)));
        end
        i_btn = '0;
        wait_cyc(600);
        done = 1'b1;
    end

    initial begin
        wait (done);
        @(negedge i_clk);
        #2;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d predicted events never seen, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
